// File: rtl/spi_pkg.sv
// Purpose: shared types and defaults for the SPI transmit arbiter slice.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
//
// Contents:
//   SPI_DATA_WIDTH / SPI_LINES : default payload shape (bits per lane, lanes)
//   state_t                    : arbiter FSM state encoding
//   payload_t                  : LINES x DATA_WIDTH packed payload at default shape
//   cnt_width()                : bits needed to hold a count of 0..max_val
package spi_pkg;

   localparam int SPI_DATA_WIDTH = 8;
   localparam int SPI_LINES      = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_START,
      ST_WAIT_DONE,
      ST_GAP
   } state_t;

   typedef logic [SPI_LINES-1:0][SPI_DATA_WIDTH-1:0] payload_t;

   // A counter that must hold every value 0..max_val without wrapping.
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Purpose: two-way round-robin pick between req0 and req1.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller gates the result with its own busy state.
//
// Ports:
//   valid0, valid1 : request valids
//   last_grant     : index of the requester that won most recently
//   winner         : index of the requester that should be served next
//   any_valid      : at least one requester is valid
module rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic winner,
   output logic any_valid
);

   always_comb begin
      any_valid = valid0 | valid1;
      // On a tie the requester that did not win last time goes next;
      // otherwise whichever is valid wins (defaults to 0 when neither is).
      if (valid0 && valid1) begin
         winner = ~last_grant;
      end else begin
         winner = valid1;
      end
   end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Purpose: round-robin arbiter feeding two requesters into one SPI sender with trigger/CS handshake.
// Latency: accept -> trigger 1 cycle; CS high -> done_out 1 cycle; then GAP_CYCLES idle before next accept.
// Backpressure: readies are high only in IDLE for the round-robin winner; anything else waits.
//
// Ports:
//   clk_in, rst_n_in                  : system clock, synchronous active-low reset
//   req0_valid/data/ready             : bulk depth-data requester
//   req1_valid/data/ready             : control/status requester
//   spi_data_out                      : payload held for the sender from accept to next accept
//   spi_trigger_out                   : one-cycle start pulse to the sender
//   spi_cs_in                         : sender chip-select, low while a transaction runs
//   grant_out                         : owner of the current/last transaction
//   done_out, timeout_out             : one-cycle completion / abort pulses
module spi_tx_arbiter
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH     = SPI_DATA_WIDTH,
   parameter int LINES          = SPI_LINES,
   parameter int GAP_CYCLES     = 4,     // at least 1
   parameter int TIMEOUT_CYCLES = 4096   // at least 2
) (
   input  logic                             clk_in,
   input  logic                             rst_n_in,

   input  logic                             req0_valid_in,
   input  logic [LINES-1:0][DATA_WIDTH-1:0] req0_data_in,
   output logic                             req0_ready_out,

   input  logic                             req1_valid_in,
   input  logic [LINES-1:0][DATA_WIDTH-1:0] req1_data_in,
   output logic                             req1_ready_out,

   output logic [LINES-1:0][DATA_WIDTH-1:0] spi_data_out,
   output logic                             spi_trigger_out,
   input  logic                             spi_cs_in,

   output logic                             grant_out,
   output logic                             done_out,
   output logic                             timeout_out
);

   localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);
   localparam int GAP_W = cnt_width(GAP_CYCLES);

   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

   state_t           state;
   logic             last_grant;
   logic [TO_W-1:0]  to_cnt;
   logic [TO_W-1:0]  to_cnt_nxt;
   logic [GAP_W-1:0] gap_cnt;

   logic             arb_winner;
   logic             arb_any;
   logic             offer;
   logic             accept0;
   logic             accept1;
   logic             to_hit;

   rr_arb2 u_rr_arb2 (
      .valid0     (req0_valid_in),
      .valid1     (req1_valid_in),
      .last_grant (last_grant),
      .winner     (arb_winner),
      .any_valid  (arb_any)
   );

   // Readies are combinational so a valid in IDLE is taken the same cycle.
   // Gating with rst_n_in keeps both low while reset is held even though
   // the state register already reads IDLE.
   assign offer          = rst_n_in && (state == ST_IDLE) && arb_any;
   assign req0_ready_out = offer && !arb_winner;
   assign req1_ready_out = offer &&  arb_winner;

   assign accept0 = req0_valid_in && req0_ready_out;
   assign accept1 = req1_valid_in && req1_ready_out;

   // The abort fires on the edge where the counter would step onto
   // TIMEOUT_CYCLES-1, so the pulse lands TIMEOUT_CYCLES cycles after LAUNCH
   // and the counter itself never has to go past that value.
   assign to_cnt_nxt = to_cnt + TO_ONE;
   assign to_hit     = (to_cnt_nxt == TO_LAST);

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state           <= ST_IDLE;
         last_grant      <= 1'b1;       // req0 wins the first tie
         grant_out       <= 1'b0;
         spi_data_out    <= '0;
         spi_trigger_out <= 1'b0;
         done_out        <= 1'b0;
         timeout_out     <= 1'b0;
         to_cnt          <= '0;
         gap_cnt         <= '0;
      end else begin
         spi_trigger_out <= 1'b0;
         done_out        <= 1'b0;
         timeout_out     <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (accept0 || accept1) begin
                  spi_data_out    <= accept1 ? req1_data_in : req0_data_in;
                  grant_out       <= accept1;
                  last_grant      <= accept1;
                  // Registered so it is high exactly during the LAUNCH cycle.
                  spi_trigger_out <= 1'b1;
                  state           <= ST_LAUNCH;
               end
            end

            ST_LAUNCH: begin
               to_cnt <= '0;
               state  <= ST_WAIT_START;
            end

            ST_WAIT_START: begin
               to_cnt <= to_cnt_nxt;
               if (to_hit) begin
                  timeout_out <= 1'b1;
                  gap_cnt     <= '0;
                  state       <= ST_GAP;
               end else if (!spi_cs_in) begin
                  state <= ST_WAIT_DONE;
               end
            end

            ST_WAIT_DONE: begin
               to_cnt <= to_cnt_nxt;
               // A completion seen on the same edge as the limit still counts
               // as a completion.
               if (spi_cs_in) begin
                  done_out <= 1'b1;
                  gap_cnt  <= '0;
                  state    <= ST_GAP;
               end else if (to_hit) begin
                  timeout_out <= 1'b1;
                  gap_cnt     <= '0;
                  state       <= ST_GAP;
               end
            end

            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_ONE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Purpose: directed self-checking bench for spi_tx_arbiter.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_tx_arbiter;
   import spi_pkg::*;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic     rst_n_in;

   // Main instance: default timeout, driven by the CS model below.
   logic     req0_valid, req1_valid, req0_ready, req1_ready;
   payload_t req0_data, req1_data, spi_data;
   logic     spi_trigger, spi_cs, grant, done, tmo;

   // Short-timeout instance whose sender never drops CS.
   logic     t_v0, t_r0, t_r1, t_trig, t_grant, t_done, t_tmo;
   payload_t t_d0, t_data;
   logic     t_v1 = 1'b0;
   payload_t t_d1 = '0;
   logic     t_cs = 1'b1;

   spi_tx_arbiter #(.DATA_WIDTH(8), .LINES(6), .GAP_CYCLES(4), .TIMEOUT_CYCLES(4096)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .req0_valid_in(req0_valid), .req0_data_in(req0_data), .req0_ready_out(req0_ready),
      .req1_valid_in(req1_valid), .req1_data_in(req1_data), .req1_ready_out(req1_ready),
      .spi_data_out(spi_data), .spi_trigger_out(spi_trigger), .spi_cs_in(spi_cs),
      .grant_out(grant), .done_out(done), .timeout_out(tmo)
   );

   spi_tx_arbiter #(.DATA_WIDTH(8), .LINES(6), .GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dut_t (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .req0_valid_in(t_v0), .req0_data_in(t_d0), .req0_ready_out(t_r0),
      .req1_valid_in(t_v1), .req1_data_in(t_d1), .req1_ready_out(t_r1),
      .spi_data_out(t_data), .spi_trigger_out(t_trig), .spi_cs_in(t_cs),
      .grant_out(t_grant), .done_out(t_done), .timeout_out(t_tmo)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_done = 0;
   int n_tmo  = 0;

   function automatic payload_t fill(input logic [7:0] b);
      payload_t p;
      for (int i = 0; i < SPI_LINES; i++) p[i] = b;
      return p;
   endfunction

   function automatic payload_t fill_inc(input logic [7:0] b);
      payload_t p;
      for (int i = 0; i < SPI_LINES; i++) p[i] = b + 8'(i);
      return p;
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sender model: CS drops the cycle after trigger and stays low 20 cycles.
   // Runs at +2 so it never races the main sequence's +1 drives.
   int low_cnt = 0;
   bit pend    = 1'b0;
   initial begin
      spi_cs = 1'b1;
      forever begin
         @(posedge clk_in);
         #2;
         if (rst_n_in !== 1'b1) begin
            spi_cs  = 1'b1;
            low_cnt = 0;
            pend    = 1'b0;
         end else begin
            if (low_cnt > 0) begin
               low_cnt--;
               if (low_cnt == 0) spi_cs = 1'b1;
            end else if (pend) begin
               pend    = 1'b0;
               spi_cs  = 1'b0;
               low_cnt = 20;
            end
            if (spi_trigger === 1'b1) pend = 1'b1;
         end
      end
   end

   // Cycle counter and pulse tallies for the main instance.
   initial begin
      forever begin
         @(posedge clk_in);
         cyc++;
         #4;
         if (done === 1'b1) n_done++;
         if (tmo === 1'b1) n_tmo++;
      end
   end

   initial begin
      int a_cyc, l_cyc, d_cyc, prev_acc, cs_rise, t_l, t_t, seen_done, base_done, base_tmo;
      bit found;
      logic cs_prev;

      // ---- reset: readies held low even with valids high ----
      rst_n_in   = 1'b0;
      req0_valid = 1'b1;  req1_valid = 1'b1;
      req0_data  = fill(8'hFF); req1_data = fill(8'hEE);
      t_v0 = 1'b1; t_d0 = fill(8'h11);
      step(); step(); settle();
      chk("rst_rdy0", req0_ready, 1'b0);
      chk("rst_rdy1", req1_ready, 1'b0);
      chk("rst_t_rdy0", t_r0, 1'b0);
      chk("rst_data", spi_data, '0);
      chk("rst_trig", spi_trigger, 1'b0);
      chk("rst_grant", grant, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_tmo", tmo, 1'b0);
      step();
      rst_n_in = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; t_v0 = 1'b0;

      // ---- both requesters continuously valid: 0,1,0,1 ----
      step();
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = fill_inc(8'h10); req1_data = fill_inc(8'h20);
      settle();
      prev_acc = 0;
      for (int k = 0; k < 4; k++) begin
         found = 1'b0;
         for (int i = 0; i < 60; i++) begin
            if (req0_ready || req1_ready) begin found = 1'b1; break; end
            step(); settle();
         end
         chk("rr_ready_seen", found, 1'b1);
         chk("rr_rdy0", req0_ready, (k % 2) == 0);
         chk("rr_rdy1", req1_ready, (k % 2) == 1);
         a_cyc = cyc;
         if (k > 0) chk("rr_period", a_cyc - prev_acc, 27);
         prev_acc = a_cyc;
         step();
         if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
         settle();
         chk("rr_trig", spi_trigger, 1'b1);
         chk("rr_grant", grant, (k % 2) == 1);
         chk("rr_data", spi_data, ((k % 2) == 1) ? fill_inc(8'h20) : fill_inc(8'h10));
         chk("rr_busy_rdy0", req0_ready, 1'b0);
         chk("rr_busy_rdy1", req1_ready, 1'b0);
         step(); settle();
      end
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin found = 1'b1; break; end
         step(); settle();
      end
      chk("rr_last_done", found, 1'b1);
      d_cyc = cyc;

      // ---- single req0, 0xA5 on all lanes ----
      step();
      req0_valid = 1'b1; req0_data = fill(8'hA5);
      settle();
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (req0_ready) begin found = 1'b1; break; end
         step(); settle();
      end
      chk("a5_ready_seen", found, 1'b1);
      chk("a5_after_gap", cyc - d_cyc, 4);
      a_cyc = cyc;
      step(); req0_valid = 1'b0; settle();
      l_cyc = cyc;
      chk("a5_trig", spi_trigger, 1'b1);
      chk("a5_trig_lat", l_cyc - a_cyc, 1);
      chk("a5_grant", grant, 1'b0);
      chk("a5_data", spi_data, fill(8'hA5));
      step(); settle();
      chk("a5_trig_fall", spi_trigger, 1'b0);
      cs_prev = spi_cs; cs_rise = 0; found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin found = 1'b1; break; end
         step(); settle();
         if (spi_cs && !cs_prev) cs_rise = cyc;
         cs_prev = spi_cs;
      end
      chk("a5_done_seen", found, 1'b1);
      chk("a5_done_lat", cyc - l_cyc, 22);
      chk("a5_done_after_cs", cyc - cs_rise, 1);
      chk("a5_tmo", tmo, 1'b0);
      d_cyc = cyc;

      // ---- valids during GAP: short req0 blip ignored, req1 ready on first IDLE ----
      step(); req0_valid = 1'b1; settle();
      chk("gap_done_pulse", done, 1'b0);
      chk("gap_rdy0", req0_ready, 1'b0);
      step(); req0_valid = 1'b0; req1_valid = 1'b1; req1_data = fill(8'h5A); settle();
      chk("gap_rdy1_d2", req1_ready, 1'b0);
      step(); settle();
      chk("gap_rdy1_d3", req1_ready, 1'b0);
      step(); settle();
      chk("gap_rdy1_idle", req1_ready, 1'b1);
      chk("gap_rdy0_idle", req0_ready, 1'b0);
      chk("gap_len", cyc - d_cyc, 4);
      step(); req1_valid = 1'b0; settle();
      l_cyc = cyc;
      chk("g1_trig", spi_trigger, 1'b1);
      chk("g1_grant", grant, 1'b1);
      chk("g1_data", spi_data, fill(8'h5A));
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin found = 1'b1; break; end
         step(); settle();
      end
      chk("g1_done_seen", found, 1'b1);
      chk("g1_done_lat", cyc - l_cyc, 22);

      // ---- reset during WAIT_DONE ----
      step(); req1_valid = 1'b1; req1_data = fill(8'hC3); settle();
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (req1_ready) begin found = 1'b1; break; end
         step(); settle();
      end
      chk("rs_ready_seen", found, 1'b1);
      step(); req1_valid = 1'b0; settle();
      chk("rs_trig", spi_trigger, 1'b1);
      chk("rs_grant_pre", grant, 1'b1);
      step(); step(); step();
      rst_n_in = 1'b0;
      settle();
      base_done = n_done; base_tmo = n_tmo;
      step(); rst_n_in = 1'b1; settle();
      chk("rs_data", spi_data, '0);
      chk("rs_grant", grant, 1'b0);
      chk("rs_trig_low", spi_trigger, 1'b0);
      chk("rs_done", done, 1'b0);
      chk("rs_tmo", tmo, 1'b0);
      repeat (30) begin step(); settle(); end
      chk("rs_no_done", n_done - base_done, 0);
      chk("rs_no_tmo", n_tmo - base_tmo, 0);
      step(); req0_valid = 1'b1; req0_data = fill(8'h3C); settle();
      chk("rs_rdy0_again", req0_ready, 1'b1);
      step(); req0_valid = 1'b0; settle();
      l_cyc = cyc;
      chk("rs2_trig", spi_trigger, 1'b1);
      chk("rs2_grant", grant, 1'b0);
      chk("rs2_data", spi_data, fill(8'h3C));
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin found = 1'b1; break; end
         step(); settle();
      end
      chk("rs2_done_seen", found, 1'b1);
      chk("rs2_done_lat", cyc - l_cyc, 22);

      // ---- timeout: CS never drops, TIMEOUT_CYCLES=16 ----
      step(); t_v0 = 1'b1; t_d0 = fill(8'h77); settle();
      chk("to_rdy", t_r0, 1'b1);
      step(); t_v0 = 1'b0; settle();
      chk("to_trig", t_trig, 1'b1);
      chk("to_data", t_data, fill(8'h77));
      t_l = cyc; seen_done = 0; found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (t_tmo) begin found = 1'b1; break; end
         step(); settle();
         if (t_done) seen_done++;
      end
      chk("to_seen", found, 1'b1);
      chk("to_lat", cyc - t_l, 16);
      chk("to_no_done", seen_done, 0);
      t_t = cyc;
      step(); t_v0 = 1'b1; settle();
      chk("to_pulse_len", t_tmo, 1'b0);
      chk("to_gap_rdy1", t_r0, 1'b0);
      step(); settle();
      chk("to_gap_rdy2", t_r0, 1'b0);
      step(); settle();
      chk("to_gap_rdy3", t_r0, 1'b0);
      step(); settle();
      chk("to_idle_rdy", t_r0, 1'b1);
      chk("to_gap_len", cyc - t_t, 4);
      step(); t_v0 = 1'b0; settle();
      chk("to_relaunch", t_trig, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, bits per lane per transaction.
REQ-002 The block SHALL have parameter LINES, default 6, parallel lanes per transaction.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 4, idle clk_in cycles with CS high between transactions (minimum 1).
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum cycles from trigger to CS returning high.
REQ-005 The block SHALL have port clk_in, input, 1 bit, 100 MHz system clock.
REQ-006 The block SHALL have port rst_n_in, input, 1 bit, reset that is synchronous and active-low.
REQ-007 The block SHALL have ports req0_valid_in (input, 1), req0_data_in (input, LINES x DATA_WIDTH) and req0_ready_out (output, 1), the bulk depth-data requester.
REQ-008 The block SHALL have ports req1_valid_in (input, 1), req1_data_in (input, LINES x DATA_WIDTH) and req1_ready_out (output, 1), the control/status requester.
REQ-009 The block SHALL have port spi_data_out, output, LINES x DATA_WIDTH, held payload driven to the SPI sender data_in.
REQ-010 The block SHALL have port spi_trigger_out, output, 1 bit, one-cycle start pulse to the SPI sender.
REQ-011 The block SHALL have port spi_cs_in, input, 1 bit, the SPI sender chip-select (low = transaction in progress).
REQ-012 The block SHALL have port grant_out, output, 1 bit, index of the requester owning the current or last transaction.
REQ-013 The block SHALL have ports done_out (output, 1) and timeout_out (output, 1), one-cycle completion and abort pulses.

Function
REQ-014 The FSM SHALL have states IDLE, LAUNCH, WAIT_START, WAIT_DONE and GAP.
REQ-015 In IDLE, arbitration SHALL be round-robin: with both valid, the requester not equal to last_grant wins; with one valid, that requester wins.
REQ-016 req*_ready_out SHALL be high only in IDLE, only for the winning requester, and combinationally from the valids and last_grant.
REQ-017 A request SHALL be accepted on a cycle where its valid and ready are both high; data SHALL be latched into spi_data_out, grant_out and last_grant SHALL update, and the FSM SHALL go to LAUNCH.
REQ-018 spi_data_out SHALL stay stable from acceptance until the next acceptance.
REQ-019 In LAUNCH, spi_trigger_out SHALL be high for exactly one cycle, and the FSM SHALL go to WAIT_START, so the trigger falls one cycle after acceptance.
REQ-020 In WAIT_START, the FSM SHALL go to WAIT_DONE when spi_cs_in is low.
REQ-021 In WAIT_DONE, the FSM SHALL wait for spi_cs_in high, then pulse done_out for one cycle and go to GAP.
REQ-022 A timeout counter SHALL clear in LAUNCH and increment in WAIT_START and WAIT_DONE.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES-1 without completion, the block SHALL pulse timeout_out (not done_out) and go to GAP.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE; no ready SHALL be asserted during GAP.
REQ-025 Counter widths SHALL be $clog2(param+1) bits; counters SHALL never wrap within a state.
REQ-026 A requester deasserting valid before acceptance SHALL cause no transaction; a valid arriving during a transaction SHALL be held off by ready low.
REQ-027 Throughput SHALL be one transaction per (1 + trigger-to-CS-high + 1 + GAP_CYCLES) cycles.

Reset
REQ-028 With rst_n_in low at a clock edge, the block SHALL enter IDLE, clear the counters, set last_grant to 1 (so req0 wins first tie), and drive spi_data_out=0, spi_trigger_out=0, grant_out=0, done_out=0, timeout_out=0 and both readies low during reset.
REQ-029 Reset mid-transaction SHALL abort without a done_out or timeout_out pulse; the external sender is reset by the same system reset.

Structure
REQ-030 A shared package spi_pkg SHALL hold the state enum type, the default DATA_WIDTH/LINES constants and the payload typedef (LINES x DATA_WIDTH packed array).
REQ-031 The round-robin decision SHALL be a sub-module rr_arb2 (inputs: two valids and last_grant; outputs: winner and any_valid).

Verification
REQ-032 Only req0 valid with data 0xA5 on all lanes, sender model dropping CS 1 cycle after trigger and raising it 20 cycles later -> trigger 1 cycle after accept, done_out 1 cycle after CS high, grant_out=0.
REQ-033 Both requesters continuously valid for 4 transactions -> grant sequence 0,1,0,1 and each ready high only in IDLE.
REQ-034 Sender model never drops CS, with TIMEOUT_CYCLES=16 -> timeout_out pulse 16 cycles after LAUNCH, no done_out, return to IDLE after GAP.
REQ-035 rst_n_in low during WAIT_DONE -> next cycle IDLE, all outputs 0, no done_out; next req0 accepted normally.
REQ-036 req1 valid rising during GAP with GAP_CYCLES=4 -> req1_ready_out high only on the first IDLE cycle, exactly 4 cycles after done_out.
